// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, states and constants for the LED scan driver
package led_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        SCAN_CLEAR,
        SCAN_SYNC,
        SCAN_RUN
    } scan_state_e;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_CONVERT,
        CONV_HOLD
    } conv_state_e;

    localparam bcd_t BLANK_CODE_DEFAULT = 4'hF;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < 20; i++) begin
            if (i < n) r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq
    import led_pkg::*;
#(
    parameter int VALUE_W    = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk_out,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int          BCD_W = 4 * NUM_DIGITS + 4;
    localparam int          CNT_W = $clog2(VALUE_W + 1);
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VALUE_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj;
    logic               ovf_q, ovf_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // done is high during the last shift so the caller can leave CONVERT on time
    assign done = busy_q && (cnt_q == CNT_W'(VALUE_W - 1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        if (busy_q) begin
            bcd_d  = (adj << 1) | BCD_W'(sh_q[VALUE_W-1]);
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q + 1'b1;
            busy_d = !done;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            sh_d   = value;
            bcd_d  = '0;
            ovf_d  = (64'(value) >= LIMIT);
        end
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign bcd      = bcd_q[4*NUM_DIGITS-1:0];
    assign overflow = ovf_q;

endmodule

// File: rtl/led_scan_driver_n.sv
// rtl/led_scan_driver_n.sv - multi-digit LED scan driver with tear-free frame commit
module led_scan_driver_n
    import led_pkg::*;
#(
    parameter int   NUM_DIGITS = 8,
    parameter int   VALUE_W    = 32,
    parameter bcd_t BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic                          clk_out,
    input  logic                          rst,
    input  logic [VALUE_W-1:0]            value_in,
    input  logic                          value_valid,
    output logic                          value_ready,
    input  logic                          blank_lz,
    output logic                          cclr_neg,
    output logic [3:0]                    num,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start,
    output logic                          overflow
);

    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e scan_q, scan_d;
    conv_state_e conv_q, conv_d;

    bcd_t disp_q     [NUM_DIGITS];
    bcd_t disp_d     [NUM_DIGITS];
    bcd_t commit_val [NUM_DIGITS];

    logic             cclr_neg_q, cclr_neg_d;
    bcd_t             num_q, num_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_start_q, frame_start_d;
    logic             overflow_q, overflow_d;
    logic             ready_q, ready_d;

    logic                    cvt_start, cvt_busy, cvt_done, cvt_ovf;
    logic [4*NUM_DIGITS-1:0] cvt_bcd;
    logic                    commit_slot;
    logic                    seen_nz;
    bcd_t                    digit;

    assign cvt_start = value_valid && ready_q && !cvt_busy;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_out  (clk_out),
        .rst      (rst),
        .start    (cvt_start),
        .value    (value_in),
        .busy     (cvt_busy),
        .done     (cvt_done),
        .bcd      (cvt_bcd),
        .overflow (cvt_ovf)
    );

    // Saturation wins over blanking; digit 0 is never blanked
    always_comb begin
        commit_val = '{default: '0};
        seen_nz    = 1'b0;
        digit      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit = cvt_bcd[4*i +: 4];
            if (cvt_ovf) commit_val[i] = 4'd9;
            else if (blank_lz && !seen_nz && digit == 4'd0 && i != 0) commit_val[i] = BLANK_CODE;
            else commit_val[i] = digit;
            seen_nz = seen_nz || (digit != 4'd0);
        end
    end

    assign commit_slot = (scan_q == SCAN_SYNC) || (scan_q == SCAN_RUN && idx_q == LAST_IDX);

    always_comb begin
        conv_d     = conv_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        case (conv_q)
            CONV_IDLE:    if (cvt_start) conv_d = CONV_CONVERT;
            CONV_CONVERT: if (cvt_done) conv_d = CONV_HOLD;
            CONV_HOLD: begin
                if (commit_slot) begin
                    conv_d     = CONV_IDLE;
                    disp_d     = commit_val;
                    overflow_d = cvt_ovf;
                end
            end
            default:      conv_d = CONV_IDLE;
        endcase
        ready_d = (conv_d == CONV_IDLE);
    end

    // num reads disp_d so the digit 0 after a commit already shows the new value
    always_comb begin
        scan_d        = scan_q;
        cclr_neg_d    = cclr_neg_q;
        idx_d         = idx_q;
        frame_start_d = 1'b0;
        case (scan_q)
            SCAN_CLEAR: begin
                scan_d     = SCAN_SYNC;
                cclr_neg_d = 1'b1;
            end
            SCAN_SYNC: begin
                scan_d        = SCAN_RUN;
                idx_d         = '0;
                frame_start_d = 1'b1;
            end
            SCAN_RUN: begin
                idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                frame_start_d = (idx_q == LAST_IDX);
            end
            default:    scan_d = SCAN_CLEAR;
        endcase
        num_d = (scan_d == SCAN_RUN) ? disp_d[idx_d] : '0;
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            scan_q        <= SCAN_CLEAR;
            conv_q        <= CONV_IDLE;
            disp_q        <= '{default: '0};
            cclr_neg_q    <= 1'b0;
            num_q         <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            scan_q        <= scan_d;
            conv_q        <= conv_d;
            disp_q        <= disp_d;
            cclr_neg_q    <= cclr_neg_d;
            num_q         <= num_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
            ready_q       <= ready_d;
        end
    end

    assign value_ready = ready_q;
    assign cclr_neg    = cclr_neg_q;
    assign num         = num_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_led_scan_driver_n.sv
// tb/tb_led_scan_driver_n.sv - scoreboard bench for led_scan_driver_n
module tb_led_scan_driver_n;

    localparam int ND = 8;
    localparam int VW = 32;

    logic          clk_out = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] value_in = '0;
    logic          value_valid = 1'b0;
    logic          blank_lz = 1'b0;
    logic          value_ready, cclr_neg, frame_start, overflow;
    logic [3:0]    num;
    logic [2:0]    digit_idx;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    logic [32:0] exp_q[$];
    logic [32:0] cur_exp = '0;

    bit          mon_locked = 1'b0;
    int          mon_pos = 0;
    logic [31:0] mon_frame = '0;
    logic        mon_ovf = 1'b0;
    logic [32:0] mon_got;

    always #5 clk_out = ~clk_out;

    led_scan_driver_n #(
        .NUM_DIGITS (ND),
        .VALUE_W    (VW),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk_out     (clk_out),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .blank_lz    (blank_lz),
        .cclr_neg    (cclr_neg),
        .num         (num),
        .digit_idx   (digit_idx),
        .frame_start (frame_start),
        .overflow    (overflow)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every displayed frame must be the current expected frame or the next queued one
    initial begin
        forever begin
            @(negedge clk_out);
            #1;
            if (rst) begin
                mon_locked = 1'b0;
                cur_exp    = '0;
            end else begin
                if (!mon_locked && frame_start) begin
                    mon_locked = 1'b1;
                    mon_pos    = 0;
                end
                if (mon_locked) begin
                    chk("digit_idx", 64'(digit_idx), 64'(mon_pos));
                    chk("frame_start", 64'(frame_start), 64'(mon_pos == 0));
                    mon_frame[4*mon_pos +: 4] = num;
                    if (mon_pos == 0) mon_ovf = overflow;
                    if (mon_pos == ND - 1) begin
                        mon_got = {mon_ovf, mon_frame};
                        frames_seen++;
                        checks++;
                        if (mon_got !== cur_exp) begin
                            if (exp_q.size() > 0 && mon_got === exp_q[0]) begin
                                cur_exp = exp_q.pop_front();
                            end else begin
                                errors++;
                                $display("FAIL frame: got %h expected %h", mon_got, cur_exp);
                            end
                        end
                    end
                    mon_pos = (mon_pos + 1) % ND;
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!value_ready && n < 500) begin
            @(negedge clk_out);
            n++;
        end
        chk(name, 64'(n < 500), 64'd1);
    endtask

    task automatic send(input logic [31:0] v, input logic bl, input logic [32:0] e);
        exp_q.push_back(e);
        value_in    = v;
        blank_lz    = bl;
        value_valid = 1'b1;
        wait_ready("accept_timeout");
        @(negedge clk_out);
        value_valid = 1'b0;
        chk("ready_drop", 64'(value_ready), 64'd0);
        wait_ready("commit_timeout");
        repeat (24) @(negedge clk_out);
    endtask

    initial begin
        time t1, t2;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1, t2;
        rst = 1'b1;
        repeat (3) @(negedge clk_out);
        chk("rst_cclr_neg", 64'(cclr_neg), 64'd0);
        chk("rst_num", 64'(num), 64'd0);
        chk("rst_digit_idx", 64'(digit_idx), 64'd0);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_value_ready", 64'(value_ready), 64'd0);
        rst = 1'b0;
        chk("clear_cclr_neg", 64'(cclr_neg), 64'd0);
        @(negedge clk_out);
        chk("sync_cclr_neg", 64'(cclr_neg), 64'd1);
        chk("sync_num", 64'(num), 64'd0);
        chk("sync_frame_start", 64'(frame_start), 64'd0);
        @(negedge clk_out);
        chk("scan_first_frame_start", 64'(frame_start), 64'd1);
        chk("scan_first_idx", 64'(digit_idx), 64'd0);
        chk("scan_first_num", 64'(num), 64'd0);
        chk("idle_ready", 64'(value_ready), 64'd1);
        repeat (20) @(negedge clk_out);

        send(32'd12345678, 1'b0, {1'b0, 32'h12345678});
        send(32'd405,      1'b1, {1'b0, 32'hFFFFF405});
        send(32'd0,        1'b1, {1'b0, 32'hFFFFFFF0});
        send(32'd100000000, 1'b0, {1'b1, 32'h99999999});
        send(32'd7,        1'b0, {1'b0, 32'h00000007});

        exp_q.push_back({1'b0, 32'h00000011});
        exp_q.push_back({1'b0, 32'h00000022});
        value_in    = 32'd11;
        blank_lz    = 1'b0;
        value_valid = 1'b1;
        wait_ready("b2b_first_timeout");
        t1 = $time;
        @(negedge clk_out);
        value_in = 32'd22;
        wait_ready("b2b_second_timeout");
        t2 = $time;
        @(negedge clk_out);
        value_valid = 1'b0;
        chk("b2b_spacing_min", 64'((t2 - t1) / 10 >= VW + 2), 64'd1);
        wait_ready("b2b_commit_timeout");
        repeat (24) @(negedge clk_out);
        chk("b2b_queue_drained", 64'(exp_q.size()), 64'd0);

        value_in    = 32'd99;
        value_valid = 1'b1;
        wait_ready("r99_accept_timeout");
        @(negedge clk_out);
        value_valid = 1'b0;
        repeat (5) @(negedge clk_out);
        rst = 1'b1;
        @(negedge clk_out);
        rst = 1'b0;
        chk("rerst_cclr_low", 64'(cclr_neg), 64'd0);
        chk("rerst_overflow", 64'(overflow), 64'd0);
        @(negedge clk_out);
        chk("rerst_cclr_high", 64'(cclr_neg), 64'd1);
        repeat (80) @(negedge clk_out);

        chk("all_frames_shown", 64'(exp_q.size()), 64'd0);
        chk("frames_observed", 64'(frames_seen >= 40), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
